// File: rtl/rvfi_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rvfi_monitor: RVFI retirement checker with a shadow register     |
// | file; reports the first protocol or architectural violation.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rvfi_monitor #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic        CHECK_MEM = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [1:0]  rvfi_mode,
  input  logic [1:0]  rvfi_ixl,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        err_valid,
  output logic [3:0]  err_code,
  output logic [63:0] err_order,
  output logic [31:0] err_insn,
  output logic        err_sticky,
  output logic [63:0] retired_count,
  output logic        halted
);

  localparam logic [1:0] c_RUN    = 2'd0;
  localparam logic [1:0] c_HALTED = 2'd1;
  localparam logic [1:0] c_FAILED = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_exp_order;
  logic [31:0] r_exp_pc;
  logic [31:0] r_shadow [1:31];
  logic [31:1] r_shadow_valid;

  logic [31:0] w_rs1_shadow;
  logic [31:0] w_rs2_shadow;
  logic [31:0] w_valid_full;
  logic        w_rs1_bad;
  logic        w_rs2_bad;
  logic        w_mem_bad;
  logic [3:0]  w_code;
  logic        w_pass;
  logic        w_shadow_wr;
  logic        w_unused;

  function automatic logic mask_bad(input logic [3:0] m);
    case (m)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_bad = 1'b0;
      default:                   mask_bad = 1'b1;
    endcase
  endfunction

  assign w_unused = ^{rvfi_intr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_addr[31:2]};

  always_comb begin
    w_rs1_shadow = '0;
    w_rs2_shadow = '0;
    for (int i = 1; i < 32; i++) begin
      if (rvfi_rs1_addr == 5'(i)) w_rs1_shadow = r_shadow[i];
      if (rvfi_rs2_addr == 5'(i)) w_rs2_shadow = r_shadow[i];
    end
  end

  assign w_valid_full = {r_shadow_valid, 1'b0};

  // Register reads compare against the pre-write shadow, so rd==rs sees the old value.
  assign w_rs1_bad = (rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != 32'd0)
                   : (w_valid_full[rvfi_rs1_addr] && (rvfi_rs1_rdata != w_rs1_shadow));
  assign w_rs2_bad = (rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != 32'd0)
                   : (w_valid_full[rvfi_rs2_addr] && (rvfi_rs2_rdata != w_rs2_shadow));

  assign w_mem_bad = CHECK_MEM &&
                     (mask_bad(rvfi_mem_rmask) || mask_bad(rvfi_mem_wmask) ||
                      (((rvfi_mem_rmask != 4'd0) || (rvfi_mem_wmask != 4'd0)) &&
                       (rvfi_mem_addr[1:0] != 2'd0)));

  always_comb begin
    w_code = 4'd0;
    if (rvfi_order != r_exp_order)                       w_code = 4'd1;
    else if (rvfi_pc_rdata != r_exp_pc)                  w_code = 4'd2;
    else if (w_rs1_bad)                                  w_code = 4'd3;
    else if (w_rs2_bad)                                  w_code = 4'd4;
    else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) w_code = 4'd5;
    else if (w_mem_bad)                                  w_code = 4'd6;
    else if ((rvfi_mode != 2'b11) || (rvfi_ixl != 2'b01)) w_code = 4'd7;
  end

  assign w_pass      = (r_state == c_RUN) && rvfi_valid && (w_code == 4'd0);
  assign w_shadow_wr = w_pass && !rvfi_trap && (rvfi_rd_addr != 5'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state        <= c_RUN;
      r_exp_order    <= 64'd0;
      r_exp_pc       <= RESET_PC;
      r_shadow_valid <= '0;
      err_valid      <= 1'b0;
      err_code       <= 4'd0;
      err_order      <= 64'd0;
      err_insn       <= 32'd0;
      err_sticky     <= 1'b0;
      retired_count  <= 64'd0;
      halted         <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (r_state)
        c_RUN: begin
          if (rvfi_valid) begin
            if (w_code != 4'd0) begin
              r_state    <= c_FAILED;
              err_valid  <= 1'b1;
              err_code   <= w_code;
              err_order  <= rvfi_order;
              err_insn   <= rvfi_insn;
              err_sticky <= 1'b1;
            end else begin
              r_exp_order   <= rvfi_order + 64'd1;
              r_exp_pc      <= rvfi_pc_wdata;
              retired_count <= retired_count + 64'd1;
              if (w_shadow_wr) r_shadow_valid[rvfi_rd_addr] <= 1'b1;
              if (rvfi_halt) begin
                r_state <= c_HALTED;
                halted  <= 1'b1;
              end
            end
          end
        end
        c_HALTED: begin
          if (rvfi_valid) begin
            r_state    <= c_FAILED;
            err_valid  <= 1'b1;
            err_code   <= 4'd8;
            err_order  <= rvfi_order;
            err_insn   <= rvfi_insn;
            err_sticky <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow data needs no reset; its valid bits gate every comparison.
  always_ff @(posedge clock) begin
    for (int i = 1; i < 32; i++) begin
      if (w_shadow_wr && (rvfi_rd_addr == 5'(i))) r_shadow[i] <= rvfi_rd_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvfi_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rvfi_monitor: directed self-checking bench for rvfi_monitor.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_rvfi_monitor;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]  rvfi_mode, rvfi_ixl;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

  logic        err_valid, err_sticky, halted;
  logic [3:0]  err_code;
  logic [63:0] err_order, retired_count;
  logic [31:0] err_insn;

  logic        nm_err_valid, nm_err_sticky, nm_halted;
  logic [3:0]  nm_err_code;
  logic [63:0] nm_err_order, nm_retired_count;
  logic [31:0] nm_err_insn;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rvfi_monitor #(.RESET_PC(32'h0000_0000), .CHECK_MEM(1'b1)) dut (
    .clock(clock), .resetn(resetn), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl), .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .err_valid(err_valid), .err_code(err_code), .err_order(err_order), .err_insn(err_insn),
    .err_sticky(err_sticky), .retired_count(retired_count), .halted(halted)
  );

  rvfi_monitor #(.RESET_PC(32'h0000_0000), .CHECK_MEM(1'b0)) dut_nm (
    .clock(clock), .resetn(resetn), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl), .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .err_valid(nm_err_valid), .err_code(nm_err_code), .err_order(nm_err_order),
    .err_insn(nm_err_insn), .err_sticky(nm_err_sticky), .retired_count(nm_retired_count),
    .halted(nm_halted)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_fields();
    rvfi_valid = 1'b0; rvfi_order = '0; rvfi_insn = 32'h0000_0013;
    rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_intr = 1'b0;
    rvfi_mode = 2'b11; rvfi_ixl = 2'b01;
    rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rd_addr = '0;
    rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0; rvfi_rd_wdata = '0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    rvfi_mem_addr = '0; rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
    rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
  endtask

  // Presents one retirement for exactly one sampling edge; returns 1 time unit after it.
  task automatic retire(input logic [63:0] ord, input logic [31:0] pc, input logic [31:0] pcw);
    rvfi_valid = 1'b1; rvfi_order = ord; rvfi_pc_rdata = pc; rvfi_pc_wdata = pcw;
    @(posedge clock);
    #1;
    clear_fields();
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    clear_fields();
    #12 resetn = 1'b1;
    @(posedge clock); #1;

    // Reset state
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_err_order", err_order, 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    chk("rst_retired", retired_count, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);

    // Three clean retirements with a shadow write and read-back
    rvfi_rd_addr = 5'd5; rvfi_rd_wdata = 32'h1234;
    retire(64'd0, 32'h0, 32'h4);
    chk("clean0_err_valid", 64'(err_valid), 64'd0);
    rvfi_rs1_addr = 5'd5; rvfi_rs1_rdata = 32'h1234;
    retire(64'd1, 32'h4, 32'h8);
    retire(64'd2, 32'h8, 32'hC);
    chk("clean_sticky", 64'(err_sticky), 64'd0);
    chk("clean_retired", retired_count, 64'd3);

    // Order skip
    pulse_reset();
    retire(64'd0, 32'h0, 32'h4);
    rvfi_insn = 32'hCAFE_0002;
    retire(64'd2, 32'h4, 32'h8);
    chk("order_err_valid", 64'(err_valid), 64'd1);
    chk("order_err_code", 64'(err_code), 64'd1);
    chk("order_err_order", err_order, 64'd2);
    chk("order_err_insn", 64'(err_insn), 64'h0000_0000_CAFE_0002);
    chk("order_err_sticky", 64'(err_sticky), 64'd1);
    retire(64'd1, 32'h4, 32'h8);
    chk("order_pulse_end", 64'(err_valid), 64'd0);
    chk("order_retired_frozen", retired_count, 64'd1);
    chk("order_code_held", 64'(err_code), 64'd1);

    // RS2 mismatch against shadow; unwritten x9 accepts anything
    pulse_reset();
    chk("rst2_sticky", 64'(err_sticky), 64'd0);
    rvfi_rd_addr = 5'd7; rvfi_rd_wdata = 32'hDEAD;
    retire(64'd0, 32'h0, 32'h4);
    rvfi_rs1_addr = 5'd9; rvfi_rs1_rdata = 32'h5555;
    retire(64'd1, 32'h4, 32'h8);
    chk("x9_unwritten_ok", 64'(err_sticky), 64'd0);
    rvfi_rs2_addr = 5'd7; rvfi_rs2_rdata = 32'hBEEF;
    retire(64'd2, 32'h8, 32'hC);
    chk("rs2_err_code", 64'(err_code), 64'd4);
    chk("rs2_err_order", err_order, 64'd2);

    // rd==rs1 sees old shadow; trapped write must not update shadow
    pulse_reset();
    rvfi_rd_addr = 5'd3; rvfi_rd_wdata = 32'h11;
    retire(64'd0, 32'h0, 32'h4);
    rvfi_rs1_addr = 5'd3; rvfi_rs1_rdata = 32'h11; rvfi_rd_addr = 5'd3; rvfi_rd_wdata = 32'h22;
    retire(64'd1, 32'h4, 32'h8);
    rvfi_trap = 1'b1; rvfi_rd_addr = 5'd3; rvfi_rd_wdata = 32'h99;
    retire(64'd2, 32'h8, 32'h100);
    rvfi_rs1_addr = 5'd3; rvfi_rs1_rdata = 32'h22;
    retire(64'd3, 32'h100, 32'h104);
    chk("shadow_old_trap_sticky", 64'(err_sticky), 64'd0);
    chk("shadow_old_trap_retired", retired_count, 64'd4);

    // Write to x0
    pulse_reset();
    rvfi_rd_wdata = 32'h1;
    retire(64'd0, 32'h0, 32'h4);
    chk("rd0_err_code", 64'(err_code), 64'd5);

    // Bad memory mask: flagged only with CHECK_MEM set
    pulse_reset();
    rvfi_mem_rmask = 4'b0110;
    retire(64'd0, 32'h0, 32'h4);
    chk("mem_err_code", 64'(err_code), 64'd6);
    chk("mem_nm_sticky", 64'(nm_err_sticky), 64'd0);
    chk("mem_nm_retired", nm_retired_count, 64'd1);

    // Misaligned word access
    pulse_reset();
    rvfi_mem_wmask = 4'b1111; rvfi_mem_addr = 32'h2;
    retire(64'd0, 32'h0, 32'h4);
    chk("mem_align_code", 64'(err_code), 64'd6);

    // Mode check; PC error outranks it
    pulse_reset();
    rvfi_mode = 2'b00;
    retire(64'd0, 32'h0, 32'h4);
    chk("mode_err_code", 64'(err_code), 64'd7);
    pulse_reset();
    rvfi_mode = 2'b00;
    retire(64'd0, 32'h40, 32'h44);
    chk("prio_pc_over_mode", 64'(err_code), 64'd2);

    // Halt then a further retirement
    pulse_reset();
    retire(64'd0, 32'h0, 32'h4);
    retire(64'd1, 32'h4, 32'h8);
    retire(64'd2, 32'h8, 32'hC);
    rvfi_halt = 1'b1;
    retire(64'd3, 32'hC, 32'h10);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_retired", retired_count, 64'd4);
    chk("halt_no_err", 64'(err_sticky), 64'd0);
    retire(64'd4, 32'h10, 32'h14);
    chk("posthalt_err_valid", 64'(err_valid), 64'd1);
    chk("posthalt_err_code", 64'(err_code), 64'd8);
    chk("posthalt_err_order", err_order, 64'd4);

    // Error, then asynchronous reset between edges, then clean restart
    pulse_reset();
    retire(64'd0, 32'h0, 32'h4);
    retire(64'd1, 32'h8, 32'hC);
    chk("pre_reset_code", 64'(err_code), 64'd2);
    resetn = 1'b0;
    #1;
    chk("async_sticky", 64'(err_sticky), 64'd0);
    chk("async_code", 64'(err_code), 64'd0);
    chk("async_order", err_order, 64'd0);
    chk("async_insn", 64'(err_insn), 64'd0);
    chk("async_retired", retired_count, 64'd0);
    resetn = 1'b1;
    #1;
    retire(64'd0, 32'h0, 32'h4);
    chk("restart_err_valid", 64'(err_valid), 64'd0);
    chk("restart_sticky", 64'(err_sticky), 64'd0);
    chk("restart_retired", retired_count, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
